// File: rtl/de_pkg.sv
`default_nettype none
// ============================================================================
// Module      : de_pkg
// Description : Shared types and constants for the decode-to-execute stage.
//               Defines the control bundle, opcode width, control bit
//               positions, the default-configuration payload struct and
//               width helpers for the flattened payload.
// Revision    : 1.0 - initial release
// ============================================================================
package de_pkg;

  localparam int CTRL_W   = 5;
  localparam int OPCODE_W = 5;

  // Bit positions inside ctrl_D / ctrl_E ({regw, memw, regmem, ALUope, branch})
  localparam int CTRL_BRANCH_BIT = 0;
  localparam int CTRL_ALUOPE_BIT = 1;
  localparam int CTRL_REGMEM_BIT = 2;
  localparam int CTRL_MEMW_BIT   = 3;
  localparam int CTRL_REGW_BIT   = 4;

  typedef struct packed {
    logic regw;
    logic memw;
    logic regmem;
    logic ALUope;
    logic branch;
  } ctrl_t;

  // Default configuration of the stage
  localparam int DEF_N     = 32;
  localparam int DEF_LANES = 4;
  localparam int DEF_M     = 4;
  localparam int DEF_L     = 3;
  localparam int DEF_V     = DEF_N * DEF_LANES;

  // Payload layout, most significant field first. The stage packs its
  // flattened payload vector in exactly this order, so the gated fields
  // (ctrl, op_code, alu_ctrl) occupy the least significant bits.
  typedef struct packed {
    logic [DEF_V-1:0]    reg_vb;
    logic [DEF_V-1:0]    reg_va;
    logic [DEF_N-1:0]    inm;
    logic [DEF_N-1:0]    reg_b;
    logic [DEF_N-1:0]    reg_a;
    logic [DEF_M-1:0]    reg_bd;
    logic [DEF_M-1:0]    reg_ad;
    logic [DEF_M-1:0]    reg_scr;
    logic [DEF_L-1:0]    alu_ctrl;
    logic [OPCODE_W-1:0] op_code;
    ctrl_t               ctrl;
  } payload_t;

  function automatic int payload_width(input int n, input int lanes,
                                       input int m, input int l);
    return 2 * lanes * n + 3 * n + 3 * m + l + OPCODE_W + CTRL_W;
  endfunction

  // Width of the low-order fields that are zeroed on flush and gated on bubbles
  function automatic int gated_width(input int l);
    return CTRL_W + OPCODE_W + l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skid_slot.sv
`default_nettype none
// ============================================================================
// Module      : skid_slot
// Description : One payload register with load enable, partial clear and
//               asynchronous active-low reset.
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-low reset, zeroes the whole slot
//   load  in  capture d (takes priority over clear)
//   clear in  zero the low CLR_W bits, the rest hold
//   d     in  W-bit payload
//   q     out W-bit stored payload
// Revision    : 1.0 - initial release
// ============================================================================
module skid_slot #(
  parameter int W     = 8,
  parameter int CLR_W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (clear) begin
      r_q[CLR_W-1:0] <= '0;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/de_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : de_skid_stage
// Description : Decode-to-execute pipeline stage with valid/ready handshake,
//               2-entry skid buffer (main + skid), flush, bubble gating of
//               the control fields and saturating stall/flush counters.
//   clk, rst               clock / asynchronous active-low reset
//   flush_E                synchronous flush of all held entries
//   in_valid / in_ready    decoder-side handshake (in_ready = ~skid valid)
//   *_D                    decoded payload inputs
//   out_valid / out_ready  execute-side handshake
//   *_E                    registered payload outputs (main slot)
//   stall_cnt              cycles with out_valid & ~out_ready
//   flush_cnt              valid entries discarded by flush
// Revision    : 1.0 - initial release
// ============================================================================
module de_skid_stage
  import de_pkg::*;
#(
  parameter int N     = 32,
  parameter int LANES = 4,
  parameter int M     = 4,
  parameter int L     = 3,
  parameter int CW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_E,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTRL_W-1:0]    ctrl_D,
  input  logic [OPCODE_W-1:0]  op_code_D,
  input  logic [L-1:0]         ALUctrl_D,
  input  logic [M-1:0]         regScr_D,
  input  logic [M-1:0]         regAD,
  input  logic [M-1:0]         regBD,
  input  logic [N-1:0]         regA_D,
  input  logic [N-1:0]         regB_D,
  input  logic [N-1:0]         inm_D,
  input  logic [LANES*N-1:0]   regVA_D,
  input  logic [LANES*N-1:0]   regVB_D,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    ctrl_E,
  output logic [OPCODE_W-1:0]  op_code_E,
  output logic [L-1:0]         ALUctrl_E,
  output logic [M-1:0]         regScr_E,
  output logic [M-1:0]         regAE,
  output logic [M-1:0]         regBE,
  output logic [N-1:0]         regA_E,
  output logic [N-1:0]         regB_E,
  output logic [N-1:0]         inm_E,
  output logic [LANES*N-1:0]   regVA_E,
  output logic [LANES*N-1:0]   regVB_E,
  output logic [CW-1:0]        stall_cnt,
  output logic [CW-1:0]        flush_cnt
);

  localparam int c_pw = payload_width(N, LANES, M, L);
  localparam int c_gw = gated_width(L);

  logic            r_main_valid;
  logic            r_skid_valid;
  logic [CW-1:0]   r_stall_cnt;
  logic [CW-1:0]   r_flush_cnt;

  logic            w_accept;
  logic            w_retire;
  logic            w_main_load;
  logic            w_skid_load;
  logic            w_main_sel_skid;
  logic            w_main_valid_nxt;
  logic            w_skid_valid_nxt;
  logic [1:0]      w_flush_drop;
  logic [CW:0]     w_flush_sum;

  logic [c_pw-1:0] w_in_payload;
  logic [c_pw-1:0] w_main_d;
  logic [c_pw-1:0] w_main_q;
  logic [c_pw-1:0] w_skid_q;

  logic [CTRL_W-1:0]   w_ctrl_q;
  logic [OPCODE_W-1:0] w_op_code_q;
  logic [L-1:0]        w_alu_ctrl_q;

  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_main_valid;

  assign w_accept = in_valid & ~r_skid_valid;
  assign w_retire = r_main_valid & out_ready;

  // Gated fields sit in the low bits so a partial clear can zero them.
  assign w_in_payload = {regVB_D, regVA_D, inm_D, regB_D, regA_D,
                         regBD, regAD, regScr_D, ALUctrl_D, op_code_D, ctrl_D};

  // Entry movement. Flush wins; otherwise the main slot is refilled from
  // the input when it is (or is becoming) empty, from the skid slot when
  // both are full and main retires, and the skid slot only catches an
  // accept that arrives while main is stalled.
  always_comb begin
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_sel_skid  = 1'b0;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;

    if (flush_E) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_main_valid || (w_retire && !r_skid_valid)) begin
      w_main_load      = w_accept;
      w_main_valid_nxt = w_accept;
    end else if (w_retire) begin
      w_main_load      = 1'b1;
      w_main_sel_skid  = 1'b1;
      w_main_valid_nxt = 1'b1;
      w_skid_valid_nxt = 1'b0;
    end else if (w_accept) begin
      w_skid_load      = 1'b1;
      w_skid_valid_nxt = 1'b1;
    end
  end

  assign w_main_d = w_main_sel_skid ? w_skid_q : w_in_payload;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

  skid_slot #(
    .W     (c_pw),
    .CLR_W (c_gw)
  ) u_main_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (w_main_load),
    .clear (flush_E),
    .d     (w_main_d),
    .q     (w_main_q)
  );

  skid_slot #(
    .W     (c_pw),
    .CLR_W (c_gw)
  ) u_skid_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (w_skid_load),
    .clear (flush_E),
    .d     (w_in_payload),
    .q     (w_skid_q)
  );

  assign {regVB_E, regVA_E, inm_E, regB_E, regA_E,
          regBE, regAE, regScr_E, w_alu_ctrl_q, w_op_code_q, w_ctrl_q} = w_main_q;

  // Bubble gating: execute never sees stale control on an empty slot.
  assign ctrl_E    = r_main_valid ? w_ctrl_q     : '0;
  assign op_code_E = r_main_valid ? w_op_code_q  : '0;
  assign ALUctrl_E = r_main_valid ? w_alu_ctrl_q : '0;

  // A main entry retiring in the flush cycle still reaches the consumer,
  // so it is not counted as discarded.
  assign w_flush_drop = flush_E ? ({1'b0, r_main_valid & ~w_retire} + {1'b0, r_skid_valid})
                                : 2'd0;
  assign w_flush_sum  = {1'b0, r_flush_cnt} + {{(CW-1){1'b0}}, w_flush_drop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_main_valid && !out_ready && (r_stall_cnt != {CW{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_sum[CW]) begin
        r_flush_cnt <= {CW{1'b1}};
      end else begin
        r_flush_cnt <= w_flush_sum[CW-1:0];
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
